// File: rtl/gpmc_sync_master_pkg.sv
// gpmc_sync_master_pkg: shared state encoding, idle strobe levels and helpers for the GPMC sync master
package gpmc_sync_master_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_ADDR  = 3'd2,
        S_WDATA = 3'd3,
        S_RDATA = 3'd4,
        S_END   = 3'd5
    } state_t;

    localparam logic CSN_IDLE  = 1'b1;
    localparam logic ADVN_IDLE = 1'b1;
    localparam logic WEIN_IDLE = 1'b1;
    localparam logic OEN_IDLE  = 1'b1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gpmc_sync_master_clk_phase.sv
// gpmc_sync_master_clk_phase: divides clk by two into gpmc_clk and flags the rising (tick) and falling edges
module gpmc_sync_master_clk_phase (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_gpmc_clk,
    output logic o_tick,
    output logic o_fall
);

    logic r_phase;

    // Free-running phase toggle; the register itself is the bus clock
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_phase <= 1'b0;
        else       r_phase <= ~r_phase;
    end

    assign o_gpmc_clk = r_phase;
    assign o_tick     = ~r_phase;
    assign o_fall     = r_phase;

endmodule

// File: rtl/gpmc_sync_master.sv
// gpmc_sync_master: turns single host read/write requests into multiplexed synchronous GPMC bus cycles
module gpmc_sync_master
    import gpmc_sync_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int WR_HOLD    = 4,
    parameter int RD_WAIT    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_write,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_gpmc_clk,
    output logic                  o_gpmc_csn,
    output logic                  o_gpmc_advn,
    output logic                  o_gpmc_wein,
    output logic                  o_gpmc_oen,
    output logic [DATA_WIDTH-1:0] o_gpmc_ad_out,
    output logic                  o_gpmc_ad_oe,
    input  logic [DATA_WIDTH-1:0] i_gpmc_ad_in
);

    localparam int CW = $clog2(max2(WR_HOLD, RD_WAIT) + 1);

    logic                  w_tick;
    logic                  w_fall;
    logic                  w_hs;
    logic                  w_cnt_zero;
    state_t                r_state;
    state_t                w_next;
    logic [CW-1:0]         r_cnt;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_ready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_csn;
    logic                  r_advn;
    logic                  r_wein;
    logic                  r_oen;
    logic                  r_ad_oe;
    logic [DATA_WIDTH-1:0] r_ad_out;

    gpmc_sync_master_clk_phase u_phase (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .o_gpmc_clk (o_gpmc_clk),
        .o_tick     (w_tick),
        .o_fall     (w_fall)
    );

    assign w_hs       = i_req_valid && r_ready;
    assign w_cnt_zero = (r_cnt == '0);

    // Next-state: every bus-phase transition waits for a tick so pins only move as gpmc_clk rises
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:           if (w_hs) w_next = S_START;
            S_START:          if (w_tick) w_next = S_ADDR;
            S_ADDR:           if (w_tick) w_next = r_write ? S_WDATA : S_RDATA;
            S_WDATA, S_RDATA: if (w_tick && w_cnt_zero) w_next = S_END;
            S_END:            if (w_tick) w_next = S_IDLE;
            default:          w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Request fields are captured only on the handshake, so later changes on req_* are ignored
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_hs) begin
            r_write <= i_req_write;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
        end
    end

    // Hold counter: loaded when ADDR ends, counts data-phase gpmc cycles down to zero
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (r_state == S_ADDR && w_tick)
            r_cnt <= r_write ? CW'(WR_HOLD - 1) : CW'(RD_WAIT - 1);
        else if ((r_state == S_WDATA || r_state == S_RDATA) && w_tick && !w_cnt_zero)
            r_cnt <= r_cnt - 1'b1;
    end

    // Bus pins registered from the next state; ad_oe drops on the same edge oen falls
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_csn    <= CSN_IDLE;
            r_advn   <= ADVN_IDLE;
            r_wein   <= WEIN_IDLE;
            r_oen    <= OEN_IDLE;
            r_ad_oe  <= 1'b0;
            r_ad_out <= '0;
        end else begin
            r_csn    <= (w_next inside {S_ADDR, S_WDATA, S_RDATA}) ? ~CSN_IDLE : CSN_IDLE;
            r_advn   <= (w_next == S_ADDR)  ? ~ADVN_IDLE : ADVN_IDLE;
            r_wein   <= (w_next == S_WDATA) ? ~WEIN_IDLE : WEIN_IDLE;
            r_oen    <= (w_next == S_RDATA) ? ~OEN_IDLE  : OEN_IDLE;
            r_ad_oe  <= (w_next inside {S_ADDR, S_WDATA});
            r_ad_out <= (w_next == S_ADDR)  ? DATA_WIDTH'(r_addr) :
                        (w_next == S_WDATA) ? r_wdata : '0;
        end
    end

    // Host side: ready mirrors an upcoming IDLE, rsp pulses on END entry, read data sampled mid last RDATA cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_ready     <= (w_next == S_IDLE);
            r_rsp_valid <= (w_next == S_END) && (r_state != S_END);
            if (r_state == S_RDATA && w_fall && w_cnt_zero) r_rdata <= i_gpmc_ad_in;
        end
    end

    assign o_req_ready   = r_ready;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_rdata   = r_rdata;
    assign o_gpmc_csn    = r_csn;
    assign o_gpmc_advn   = r_advn;
    assign o_gpmc_wein   = r_wein;
    assign o_gpmc_oen    = r_oen;
    assign o_gpmc_ad_oe  = r_ad_oe;
    assign o_gpmc_ad_out = r_ad_out;

endmodule

// File: tb/tb_gpmc_sync_master.sv
// tb_gpmc_sync_master: drives the master against a behavioural GPMC target with a 16x16 register file
module tb_gpmc_sync_master;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int WR_HOLD = 4;
    localparam int RD_WAIT = 4;
    localparam int W_LAT = 2 * (WR_HOLD + 1) + 1;
    localparam int R_LAT = 2 * (RD_WAIT + 1) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          gpmc_clk, csn, advn, wein, oen, ad_oe;
    logic [DW-1:0] ad_out;
    logic [DW-1:0] ad_in;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    gpmc_sync_master #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .WR_HOLD    (WR_HOLD),
        .RD_WAIT    (RD_WAIT)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_write   (req_write),
        .i_req_addr    (req_addr),
        .i_req_wdata   (req_wdata),
        .o_rsp_valid   (rsp_valid),
        .o_rsp_rdata   (rsp_rdata),
        .o_gpmc_clk    (gpmc_clk),
        .o_gpmc_csn    (csn),
        .o_gpmc_advn   (advn),
        .o_gpmc_wein   (wein),
        .o_gpmc_oen    (oen),
        .o_gpmc_ad_out (ad_out),
        .o_gpmc_ad_oe  (ad_oe),
        .i_gpmc_ad_in  (ad_in)
    );

    // Target: latches address on advn, writes on wein, presents read data only in the last oen cycle
    logic [DW-1:0] t_mem [16];
    logic [AW-1:0] t_addr = '0;
    int            t_rd = 0;
    initial foreach (t_mem[i]) t_mem[i] = '0;
    always @(negedge gpmc_clk) begin
        if (!csn && !advn) t_addr <= ad_out[AW-1:0];
        if (!csn && !wein && ad_oe) t_mem[t_addr] <= ad_out;
        t_rd <= (!oen) ? t_rd + 1 : 0;
    end
    assign ad_in = (!oen && t_rd == RD_WAIT - 1) ? t_mem[t_addr] : ~t_mem[t_addr];

    // Reference: what the register file must hold and what the last read must return
    logic [DW-1:0] model [16];
    logic [DW-1:0] last_rd = '0;
    initial foreach (model[i]) model[i] = '0;

    // Bus observer
    int advn_clks, wein_clks, oen_clks, wein_ad_chg, oe_conflict, rsp_cnt, hi_run, min_gap;
    int align_bad = 0;
    logic seen_low;
    logic [DW-1:0] advn_ad, wein_ad;
    logic [DW+4:0] prev_bus = {5'b11110, {DW{1'b0}}};

    task automatic clr_mon();
        advn_clks = 0; wein_clks = 0; oen_clks = 0; wein_ad_chg = 0; oe_conflict = 0;
        rsp_cnt = 0; hi_run = 0; min_gap = 1000; seen_low = 1'b0; advn_ad = '0; wein_ad = '0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (!advn) begin advn_clks++; advn_ad = ad_out; end
            if (!wein) begin
                if (wein_clks > 0 && ad_out !== wein_ad) wein_ad_chg++;
                wein_ad = ad_out;
                wein_clks++;
            end
            if (!oen) oen_clks++;
            if (!oen && ad_oe) oe_conflict++;
            if (rsp_valid) rsp_cnt++;
            if (csn) hi_run++;
            else begin
                if (seen_low && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
                hi_run = 0;
                seen_low = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst && {csn, advn, wein, oen, ad_oe, ad_out} !== prev_bus && !gpmc_clk) align_bad++;
        prev_bus = {csn, advn, wein, oen, ad_oe, ad_out};
    end

    // Stimulus helper: one handshake, then wait for the response; returns latency in clk
    task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int lat, output bit to);
        int n;
        to = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        n = 0;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) to = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; req_write = $urandom; req_addr = $urandom; req_wdata = $urandom;
        lat = 0;
        while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
        if (lat >= 200) to = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({gpmc_clk, csn, advn, wein, oen, ad_oe, req_ready, rsp_valid} !== 8'b0111_1000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 01111000",
                     {gpmc_clk, csn, advn, wein, oen, ad_oe, req_ready, rsp_valid});
        end
        vectors++;
        if (ad_out !== '0 || rsp_rdata !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got ad=%h rdata=%h expected 0", ad_out, rsp_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_write();
        int lat; bit to;
        clr_mon();
        do_req(1'b1, 4'h3, 16'hBEEF, lat, to);
        model[3] = 16'hBEEF;
        vectors++;
        if (to || lat < W_LAT || lat > W_LAT + 1) begin
            miscompares++;
            $display("FAIL write_latency: got %0d (timeout %0d) expected %0d..%0d", lat, to, W_LAT, W_LAT + 1);
        end
        @(negedge clk); #1;
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_cnt != 1) begin
            miscompares++;
            $display("FAIL write_rsp_pulse: got valid=%b count=%0d expected 0 and 1", rsp_valid, rsp_cnt);
        end
        vectors++;
        if (advn_clks != 2 || advn_ad !== 16'h0003) begin
            miscompares++;
            $display("FAIL write_addr_phase: got %0d clk ad=%h expected 2 clk ad=0003", advn_clks, advn_ad);
        end
        vectors++;
        if (wein_clks != 2 * WR_HOLD || wein_ad !== 16'hBEEF || wein_ad_chg != 0) begin
            miscompares++;
            $display("FAIL write_data_phase: got %0d clk ad=%h changes=%0d expected %0d clk ad=beef changes=0",
                     wein_clks, wein_ad, wein_ad_chg, 2 * WR_HOLD);
        end
        vectors++;
        if (t_mem[3] !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL write_landed: got %h expected beef", t_mem[3]);
        end
    endtask

    task automatic test_read();
        int lat; bit to;
        clr_mon();
        do_req(1'b0, 4'h3, 16'h0000, lat, to);
        last_rd = model[3];
        vectors++;
        if (to || lat < R_LAT || lat > R_LAT + 1) begin
            miscompares++;
            $display("FAIL read_latency: got %0d (timeout %0d) expected %0d..%0d", lat, to, R_LAT, R_LAT + 1);
        end
        vectors++;
        if (rsp_rdata !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL read_data: got %h expected beef", rsp_rdata);
        end
        @(negedge clk); #1;
        vectors++;
        if (oe_conflict != 0 || oen_clks != 2 * RD_WAIT || wein_clks != 0) begin
            miscompares++;
            $display("FAIL read_strobes: got conflicts=%0d oen=%0d wein=%0d expected 0 %0d 0",
                     oe_conflict, oen_clks, wein_clks, 2 * RD_WAIT);
        end
        vectors++;
        if (rsp_cnt != 1 || advn_clks != 2) begin
            miscompares++;
            $display("FAIL read_single: got rsp=%0d advn=%0d expected 1 and 2", rsp_cnt, advn_clks);
        end
    endtask

    task automatic test_back_to_back();
        int n; bit saw_rsp;
        clr_mon();
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h1; req_wdata = 16'h1111;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        req_addr = 4'h2; req_wdata = 16'h2222;
        saw_rsp = 1'b0; n = 0;
        while (!req_ready && n < 50) begin
            if (rsp_valid) saw_rsp = 1'b1;
            @(negedge clk); n++;
        end
        vectors++;
        if (!saw_rsp || n >= 50) begin
            miscompares++;
            $display("FAIL b2b_second_accept: got first_rsp=%b wait=%0d expected 1 and <50", saw_rsp, n);
        end
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        @(negedge clk); #1;
        model[1] = 16'h1111; model[2] = 16'h2222;
        vectors++;
        if (rsp_cnt != 2 || advn_clks != 4 || wein_clks != 4 * WR_HOLD) begin
            miscompares++;
            $display("FAIL b2b_count: got rsp=%0d advn=%0d wein=%0d expected 2 4 %0d",
                     rsp_cnt, advn_clks, wein_clks, 4 * WR_HOLD);
        end
        vectors++;
        if (min_gap < 2 || min_gap >= 1000) begin
            miscompares++;
            $display("FAIL b2b_csn_gap: got %0d clk expected >=2", min_gap);
        end
        vectors++;
        if (t_mem[1] !== 16'h1111 || t_mem[2] !== 16'h2222) begin
            miscompares++;
            $display("FAIL b2b_landed: got %h %h expected 1111 2222", t_mem[1], t_mem[2]);
        end
    endtask

    task automatic test_busy_toggle();
        int n, ready_bad;
        logic [DW-1:0] d;
        bit mem_ok;
        clr_mon();
        d = DW'($urandom);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h5; req_wdata = d;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        ready_bad = 0; n = 0;
        while (!rsp_valid && n < 50) begin
            if (req_ready) ready_bad++;
            req_valid = $urandom; req_write = $urandom;
            req_addr = AW'($urandom_range(6, 15)); req_wdata = DW'($urandom);
            @(negedge clk); n++;
        end
        req_valid = 1'b0;
        model[5] = d;
        repeat (6) @(negedge clk);
        #1;
        vectors++;
        if (ready_bad != 0 || n >= 50) begin
            miscompares++;
            $display("FAIL busy_ready: got %0d ready-high clk (wait %0d) expected 0", ready_bad, n);
        end
        vectors++;
        if (rsp_cnt != 1 || advn_clks != 2) begin
            miscompares++;
            $display("FAIL busy_extra_transfer: got rsp=%0d advn=%0d expected 1 and 2", rsp_cnt, advn_clks);
        end
        mem_ok = 1'b1;
        foreach (model[i]) if (t_mem[i] !== model[i]) mem_ok = 1'b0;
        vectors++;
        if (!mem_ok) begin
            miscompares++;
            $display("FAIL busy_memory: got reg5=%h expected %h with other registers untouched", t_mem[5], d);
        end
    endtask

    task automatic test_reset_mid_wdata();
        int n, lat; bit to;
        logic [DW-1:0] d, d2;
        clr_mon();
        d = DW'($urandom); d2 = DW'($urandom);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h7; req_wdata = d;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (wein && n < 50) begin @(negedge clk); n++; end
        vectors++;
        if (n >= 50) begin
            miscompares++;
            $display("FAIL rstmid_wein_timeout: got wein=%b expected 0", wein);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({csn, wein, ad_oe, gpmc_clk, req_ready} !== 5'b11000) begin
            miscompares++;
            $display("FAIL rstmid_async: got csn,wein,oe,gclk,ready=%b expected 11000",
                     {csn, wein, ad_oe, gpmc_clk, req_ready});
        end
        model[7] = d;
        last_rd = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        vectors++;
        if (rsp_cnt != 0 || rsp_rdata !== '0) begin
            miscompares++;
            $display("FAIL rstmid_no_rsp: got rsp=%0d rdata=%h expected 0 and 0", rsp_cnt, rsp_rdata);
        end
        do_req(1'b1, 4'h7, d2, lat, to);
        model[7] = d2;
        vectors++;
        if (to || lat < W_LAT || lat > W_LAT + 1) begin
            miscompares++;
            $display("FAIL rstmid_next_write: got %0d (timeout %0d) expected %0d..%0d", lat, to, W_LAT, W_LAT + 1);
        end
        do_req(1'b0, 4'h7, '0, lat, to);
        last_rd = model[7];
        vectors++;
        if (to || rsp_rdata !== d2) begin
            miscompares++;
            $display("FAIL rstmid_next_read: got %h (timeout %0d) expected %h", rsp_rdata, to, d2);
        end
    endtask

    task automatic test_random();
        int lat; bit to;
        logic w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        for (int k = 0; k < 24; k++) begin
            w = $urandom; a = AW'($urandom); d = DW'($urandom);
            do_req(w, a, d, lat, to);
            vectors++;
            if (to || lat < (w ? W_LAT : R_LAT) || lat > (w ? W_LAT : R_LAT) + 1) begin
                miscompares++;
                $display("FAIL rand_latency[%0d]: got %0d (timeout %0d) write=%b", k, lat, to, w);
            end
            if (w) model[a] = d;
            else   last_rd = model[a];
            vectors++;
            if (rsp_rdata !== last_rd) begin
                miscompares++;
                $display("FAIL rand_rdata[%0d]: got %h expected %h (write=%b addr=%h)", k, rsp_rdata, last_rd, w, a);
            end
            @(negedge clk);
            vectors++;
            if (rsp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rand_rsp_pulse[%0d]: got %b expected 0", k, rsp_valid);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        #1;
        vectors++;
        if (align_bad != 0) begin
            miscompares++;
            $display("FAIL bus_alignment: got %0d changes off tick expected 0", align_bad);
        end
    endtask

    initial begin
        clr_mon();
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_busy_toggle();
        test_reset_mid_wdata();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
